pndes: RTL and testbench

Serial-to-parallel receiver; the deserializing counterpart of the pnser serializer in assign0.
- Collects a frame of 1..32 serial bits, MSB first, qualified by a bit strobe and framed by a start-of-frame flag.
- Presents the assembled word right-aligned on a parallel bus with a one-cycle valid pulse.
- Sits at the far end of the serial link, feeding word-oriented logic.

---
 rtl/pndes.sv | 88 ++++++++
 tb/tb_pndes.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pndes.sv
// Serial-to-parallel receiver: MSB-first frames of 1..DW bits, framed by sof, strobed by bit_vld.
// Completed word appears right-aligned on dat_o with a one-cycle vld_o pulse; a sof mid-frame aborts with err_o.
module pndes #(
  parameter int DW = 32,
  parameter int LW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          dat_i,
  input  logic          bit_vld_i,
  input  logic          sof_i,
  input  logic [LW-1:0] len_i,
  output logic [DW-1:0] dat_o,
  output logic          vld_o,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LW:0] DW_LEN = (LW+1)'(DW);

  state_t        state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [LW:0]   rem_q, rem_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic [LW:0]   n_len;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    dat_d   = dat_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    n_len   = (len_i == '0) ? DW_LEN : {1'b0, len_i};

    if (bit_vld_i) begin
      if (sof_i) begin
        // A sof always starts a fresh frame; in SHIFT it also discards the partial one.
        err_d   = (state_q == SHIFT);
        shreg_d = {{(DW-1){1'b0}}, dat_i};
        rem_d   = n_len - 1'b1;
        if (n_len == (LW+1)'(1)) begin
          dat_d   = shreg_d;
          vld_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
        end
      end else if (state_q == SHIFT) begin
        shreg_d = {shreg_q[DW-2:0], dat_i};
        rem_d   = rem_q - 1'b1;
        if (rem_q == (LW+1)'(1)) begin
          dat_d   = shreg_d;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign dat_o  = dat_q;
  assign vld_o  = vld_q;
  assign busy_o = (state_q == SHIFT);
  assign err_o  = err_q;

endmodule

// File: tb/tb_pndes.sv
// Directed bench for pndes: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_pndes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dat;
  logic        bit_vld;
  logic        sof;
  logic [4:0]  len;
  logic [31:0] dat_o;
  logic        vld_o;
  logic        busy_o;
  logic        err_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_vld_cyc = 0;
  int prev_vld_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pndes #(.DW(32), .LW(5)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .dat_i    (dat),
    .bit_vld_i(bit_vld),
    .sof_i    (sof),
    .len_i    (len),
    .dat_o    (dat_o),
    .vld_o    (vld_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  typedef struct {
    logic        rst_n;
    logic        sof;
    logic        vld;
    logic        dat;
    logic [4:0]  len;
    logic        e_vld;
    logic        e_busy;
    logic        e_err;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic r, input logic s, input logic v, input logic d, input logic [4:0] l);
    @(negedge clk);
    rst_n = r; sof = s; bit_vld = v; dat = d; len = l;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string name, input logic [31:0] word, input int n,
                            input logic [4:0] l, input int gap);
    logic [63:0] mask;
    mask = (64'd1 << n) - 64'd1;
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b1, (i == n - 1), 1'b1, word[i], l);
      chk({name, ".err"}, {31'd0, err_o}, 32'd0);
      if (i > 0) begin
        chk({name, ".vld_early"}, {31'd0, vld_o}, 32'd0);
        chk({name, ".busy"}, {31'd0, busy_o}, 32'd1);
        for (int g = 0; g < gap; g++) begin
          drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
          chk({name, ".gap_vld"}, {31'd0, vld_o}, 32'd0);
          chk({name, ".gap_busy"}, {31'd0, busy_o}, 32'd1);
        end
      end else begin
        chk({name, ".vld"}, {31'd0, vld_o}, 32'd1);
        chk({name, ".busy_done"}, {31'd0, busy_o}, 32'd0);
        chk({name, ".dat"}, dat_o, word & mask[31:0]);
        prev_vld_cyc = last_vld_cyc;
        last_vld_cyc = cyc;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sof = 1'b0; bit_vld = 1'b0; dat = 1'b0; len = 5'd0;

    // reset, 0xAB len 8 contiguous, then abort by len-4 frame 1101
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'hAB};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'hAB};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 32'hAB};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAB};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAB};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAB};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 32'hAB};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 32'hAB};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAB};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'hD};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hD};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst_n, tbl[i].sof, tbl[i].vld, tbl[i].dat, tbl[i].len);
      chk($sformatf("tbl%0d.dat", i), dat_o, tbl[i].e_dat);
      chk($sformatf("tbl%0d.vld", i), {31'd0, vld_o}, {31'd0, tbl[i].e_vld});
      chk($sformatf("tbl%0d.busy", i), {31'd0, busy_o}, {31'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d.err", i), {31'd0, err_o}, {31'd0, tbl[i].e_err});
    end

    // gapped 12-bit frame
    send_frame("gap12", 32'h9AB, 12, 5'd12, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("gap12.vld_once", {31'd0, vld_o}, 32'd0);

    // full-width frame via len 0, then single-bit frame
    send_frame("full32", 32'hDEADBEEF, 32, 5'd0, 0);
    send_frame("len1", 32'h1, 1, 5'd1, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("len1.vld_clear", {31'd0, vld_o}, 32'd0);
    chk("len1.dat_hold", dat_o, 32'h1);

    // reset mid-frame
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
    chk("rst.dat", dat_o, 32'h0);
    chk("rst.vld", {31'd0, vld_o}, 32'd0);
    chk("rst.busy", {31'd0, busy_o}, 32'd0);
    chk("rst.err", {31'd0, err_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
      chk("stray.busy", {31'd0, busy_o}, 32'd0);
      chk("stray.vld", {31'd0, vld_o}, 32'd0);
    end
    chk("stray.dat", dat_o, 32'h0);
    send_frame("after_rst", 32'h3C, 8, 5'd8, 0);

    // back-to-back frames
    send_frame("b2b_a", 32'hAB, 8, 5'd8, 0);
    send_frame("b2b_b", 32'h55, 8, 5'd8, 0);
    chk("b2b.spacing", 32'(last_vld_cyc - prev_vld_cyc), 32'd8);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("b2b.vld_clear", {31'd0, vld_o}, 32'd0);
    chk("b2b.dat_hold", dat_o, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
